// File: rtl/data_mem_arbiter.sv
// Arbitrates the shared data memory between the core MEM stage and a host/loader port.
// Core has priority; host gets a starvation cap and an optional exclusive lock mode.
module data_mem_arbiter #(
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 8,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              core_req_i,
    input  logic              core_we_i,
    input  logic [ADDR_W-1:0] core_addr_i,
    input  logic [DATA_W-1:0] core_wdata_i,
    output logic              core_stall_o,
    output logic [DATA_W-1:0] core_rdata_o,
    input  logic              host_req_i,
    input  logic              host_we_i,
    input  logic [ADDR_W-1:0] host_addr_i,
    input  logic [DATA_W-1:0] host_wdata_i,
    input  logic              host_lock_i,
    output logic              host_gnt_o,
    output logic [DATA_W-1:0] host_rdata_o,
    output logic              host_rvalid_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_raddr_o,
    output logic [ADDR_W-1:0] mem_waddr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i
);
    localparam int WAIT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);

    typedef enum logic {SHARED, LOCKED} state_t;

    state_t             state_q, state_d;
    logic [WAIT_W-1:0]  host_wait_q, host_wait_d;
    logic [DATA_W-1:0]  host_rdata_q, host_rdata_d;
    logic               host_rvalid_q, host_rvalid_d;
    logic               locked_eff, host_at_cap, gnt_host, gnt_core;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q       <= SHARED;
            host_wait_q   <= '0;
            host_rvalid_q <= 1'b0;
            host_rdata_q  <= '0;
        end else begin
            state_q       <= state_d;
            host_wait_q   <= host_wait_d;
            host_rvalid_q <= host_rvalid_d;
            host_rdata_q  <= host_rdata_d;
        end
    end

    always_comb begin
        // In the reset cycle the registered state is ignored: plain SHARED rules, wait = 0.
        locked_eff    = !reset_i && (state_q == LOCKED) && host_lock_i;
        host_at_cap   = !reset_i && (host_wait_q == WAIT_W'(MAX_WAIT));
        gnt_host      = 1'b0;
        gnt_core      = 1'b0;
        mem_we_o      = 1'b0;
        mem_raddr_o   = '0;
        mem_waddr_o   = '0;
        mem_wdata_o   = '0;
        state_d       = state_q;
        host_wait_d   = host_wait_q;
        host_rvalid_d = 1'b0;
        host_rdata_d  = host_rdata_q;

        if (locked_eff) begin
            gnt_host = host_req_i;
        end else if (host_req_i && (host_at_cap || !core_req_i)) begin
            gnt_host = 1'b1;
        end else if (core_req_i) begin
            gnt_core = 1'b1;
        end

        if (gnt_host) begin
            mem_we_o    = host_we_i;
            mem_raddr_o = host_addr_i;
            mem_waddr_o = host_addr_i;
            mem_wdata_o = host_wdata_i;
        end else if (gnt_core) begin
            mem_we_o    = core_we_i;
            mem_raddr_o = core_addr_i;
            mem_waddr_o = core_addr_i;
            mem_wdata_o = core_wdata_i;
        end

        if (gnt_host || !host_req_i) begin
            host_wait_d = '0;
        end else if (!host_at_cap) begin
            host_wait_d = (reset_i ? '0 : host_wait_q) + WAIT_W'(1);
        end

        // Lock is only taken on a host grant; dropping host_lock releases it immediately.
        if (locked_eff) begin
            state_d = LOCKED;
        end else begin
            state_d = (gnt_host && host_lock_i) ? LOCKED : SHARED;
        end

        if (gnt_host && !host_we_i) begin
            host_rvalid_d = 1'b1;
            host_rdata_d  = mem_rdata_i;
        end
    end

    assign core_stall_o  = core_req_i && !gnt_core;
    assign core_rdata_o  = mem_rdata_i;
    assign host_gnt_o    = gnt_host;
    assign host_rdata_o  = host_rdata_q;
    assign host_rvalid_o = host_rvalid_q;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter: a RAM model, a per-cycle reference model of the arbitration
// rules, and directed scenarios with hand-computed literal expectations.
module tb_data_mem_arbiter;
    localparam int ADDR_W   = 5;
    localparam int DATA_W   = 8;
    localparam int MAX_WAIT = 4;

    logic              clk_i = 1'b0;
    logic              reset_i;
    logic              core_req_i, core_we_i;
    logic [ADDR_W-1:0] core_addr_i;
    logic [DATA_W-1:0] core_wdata_i;
    logic              core_stall_o;
    logic [DATA_W-1:0] core_rdata_o;
    logic              host_req_i, host_we_i, host_lock_i;
    logic [ADDR_W-1:0] host_addr_i;
    logic [DATA_W-1:0] host_wdata_i;
    logic              host_gnt_o, host_rvalid_o;
    logic [DATA_W-1:0] host_rdata_o;
    logic              mem_we_o;
    logic [ADDR_W-1:0] mem_raddr_o, mem_waddr_o;
    logic [DATA_W-1:0] mem_wdata_o, mem_rdata_i;

    logic [DATA_W-1:0] ram [32];
    int n_vec = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    bit              m_locked = 1'b0, nx_locked;
    int              m_wait = 0, nx_wait;
    bit              m_rvalid = 1'b0, nx_rvalid;
    logic [DATA_W-1:0] m_rdata = '0, nx_rdata;

    data_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(MAX_WAIT)) dut (
        .clk_i(clk_i), .reset_i(reset_i),
        .core_req_i(core_req_i), .core_we_i(core_we_i), .core_addr_i(core_addr_i),
        .core_wdata_i(core_wdata_i), .core_stall_o(core_stall_o), .core_rdata_o(core_rdata_o),
        .host_req_i(host_req_i), .host_we_i(host_we_i), .host_addr_i(host_addr_i),
        .host_wdata_i(host_wdata_i), .host_lock_i(host_lock_i), .host_gnt_o(host_gnt_o),
        .host_rdata_o(host_rdata_o), .host_rvalid_o(host_rvalid_o),
        .mem_we_o(mem_we_o), .mem_raddr_o(mem_raddr_o), .mem_waddr_o(mem_waddr_o),
        .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    assign mem_rdata_i = ram[mem_raddr_o];
    always @(posedge clk_i) if (mem_we_o === 1'b1) ram[mem_waddr_o] <= mem_wdata_o;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: decide who owns the memory this cycle from the rules, then what it implies.
    always @(negedge clk_i) begin
        bit lk, e_hg, e_cg, e_we;
        int w;
        logic [ADDR_W-1:0] e_addr;
        logic [DATA_W-1:0] e_wd;
        lk   = !reset_i && m_locked && host_lock_i;
        w    = reset_i ? 0 : m_wait;
        e_hg = lk ? host_req_i : (host_req_i && (w >= MAX_WAIT || !core_req_i));
        e_cg = !lk && !e_hg && core_req_i;
        e_we = e_hg ? host_we_i : (e_cg ? core_we_i : 1'b0);
        e_addr = e_hg ? host_addr_i : (e_cg ? core_addr_i : '0);
        e_wd   = e_hg ? host_wdata_i : (e_cg ? core_wdata_i : '0);
        if (chk_en) begin
            chk("m_core_stall", core_stall_o, core_req_i && !e_cg);
            chk("m_host_gnt", host_gnt_o, e_hg);
            chk("m_mem_we", mem_we_o, e_we);
            chk("m_mem_raddr", mem_raddr_o, e_addr);
            chk("m_mem_waddr", mem_waddr_o, e_addr);
            chk("m_mem_wdata", mem_wdata_o, e_wd);
            chk("m_core_rdata", core_rdata_o, ram[e_addr]);
            chk("m_host_rvalid", host_rvalid_o, m_rvalid);
            chk("m_host_rdata", host_rdata_o, m_rdata);
        end
        nx_locked = !reset_i && (lk || (e_hg && host_lock_i));
        nx_wait   = (reset_i || e_hg || !host_req_i) ? 0 : ((w + 1 > MAX_WAIT) ? MAX_WAIT : w + 1);
        nx_rvalid = !reset_i && e_hg && !host_we_i;
        nx_rdata  = reset_i ? '0 : (nx_rvalid ? ram[host_addr_i] : m_rdata);
    end

    always @(posedge clk_i) begin
        m_locked <= nx_locked;
        m_wait   <= nx_wait;
        m_rvalid <= nx_rvalid;
        m_rdata  <= nx_rdata;
    end

    task automatic drive(input logic rst, input logic cr, input logic cw, input logic [4:0] ca,
                         input logic [7:0] cd, input logic hr, input logic hw, input logic [4:0] ha,
                         input logic [7:0] hd, input logic hl);
        reset_i = rst; core_req_i = cr; core_we_i = cw; core_addr_i = ca; core_wdata_i = cd;
        host_req_i = hr; host_we_i = hw; host_addr_i = ha; host_wdata_i = hd; host_lock_i = hl;
        #3;
    endtask

    task automatic nxt();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) ram[i] = 8'(i * 7 + 1);
        ram[3] = 8'h21;

        // Reset with both requesting: core wins
        drive(1, 1, 0, 5'd0, 8'h00, 1, 0, 5'd3, 8'h00, 0);
        chk("rst_core_stall", core_stall_o, 0);
        chk("rst_host_gnt", host_gnt_o, 0);
        nxt();
        drive(1, 0, 0, 5'd0, 8'h00, 0, 0, 5'd0, 8'h00, 0);
        chk("rst_idle_we", mem_we_o, 0);
        chk("rst_idle_stall", core_stall_o, 0);
        nxt();
        chk("rst_rvalid", host_rvalid_o, 0);
        chk("rst_rdata", host_rdata_o, 0);
        chk_en = 1'b1;

        // Core-only traffic
        drive(0, 1, 1, 5'd7, 8'h5A, 0, 0, 5'd0, 8'h00, 0);
        chk("cw_stall", core_stall_o, 0);
        chk("cw_waddr", mem_waddr_o, 7);
        nxt();
        drive(0, 1, 0, 5'd7, 8'h00, 0, 0, 5'd0, 8'h00, 0);
        chk("cr_rdata", core_rdata_o, 8'h5A);
        chk("cr_stall", core_stall_o, 0);
        nxt();

        // Starvation cap: host denied 4 cycles, granted on the 5th
        for (int c = 1; c <= 5; c++) begin
            drive(0, 1, 0, 5'd10, 8'h00, 1, 0, 5'd3, 8'h00, 0);
            chk("starve_gnt", host_gnt_o, (c == 5));
            chk("starve_stall", core_stall_o, (c == 5));
            nxt();
        end
        drive(0, 1, 0, 5'd10, 8'h00, 0, 0, 5'd0, 8'h00, 0);
        chk("starve_rvalid", host_rvalid_o, 1);
        chk("starve_rdata", host_rdata_o, 8'h21);
        chk("starve_after_stall", core_stall_o, 0);
        nxt();

        // Idle core: host write goes straight through
        drive(0, 0, 0, 5'd0, 8'h00, 1, 1, 5'd31, 8'hFF, 0);
        chk("hw_gnt", host_gnt_o, 1);
        chk("hw_we", mem_we_o, 1);
        chk("hw_waddr", mem_waddr_o, 31);
        nxt();
        drive(0, 0, 0, 5'd0, 8'h00, 0, 0, 5'd0, 8'h00, 0);
        chk("hw_no_rvalid", host_rvalid_o, 0);
        nxt();

        // Host lock held while core waits, then released
        drive(0, 0, 0, 5'd0, 8'h00, 1, 0, 5'd31, 8'h00, 1);
        chk("lk_gnt", host_gnt_o, 1);
        nxt();
        for (int a = 0; a < 8; a++) begin
            drive(0, 1, 0, 5'd9, 8'h00, 1, 1, 5'(a), 8'(8'h80 + a), 1);
            chk("lk_stall", core_stall_o, 1);
            chk("lk_host_gnt", host_gnt_o, 1);
            nxt();
        end
        drive(0, 1, 0, 5'd5, 8'h00, 0, 0, 5'd0, 8'h00, 0);
        chk("unlk_stall", core_stall_o, 0);
        chk("unlk_rdata", core_rdata_o, 8'h85);
        nxt();

        // Reset while locked, host idle
        drive(0, 0, 0, 5'd0, 8'h00, 1, 0, 5'd2, 8'h00, 1);
        nxt();
        drive(0, 1, 0, 5'd4, 8'h00, 0, 0, 5'd0, 8'h00, 1);
        chk("lk2_stall", core_stall_o, 1);
        nxt();
        drive(1, 1, 0, 5'd4, 8'h00, 0, 0, 5'd0, 8'h00, 1);
        chk("rstlk_stall", core_stall_o, 0);
        nxt();
        drive(0, 1, 0, 5'd4, 8'h00, 0, 0, 5'd0, 8'h00, 1);
        chk("rstlk_shared", core_stall_o, 0);
        nxt();

        // Reset while locked, host still requesting
        drive(0, 0, 0, 5'd0, 8'h00, 1, 0, 5'd2, 8'h00, 1);
        nxt();
        drive(1, 1, 0, 5'd6, 8'h00, 1, 0, 5'd2, 8'h00, 1);
        chk("rstlk2_stall", core_stall_o, 0);
        chk("rstlk2_gnt", host_gnt_o, 0);
        nxt();
        drive(0, 1, 0, 5'd6, 8'h00, 1, 0, 5'd2, 8'h00, 1);
        chk("rstlk2_next", core_stall_o, 0);
        nxt();

        // Host read granted in a reset cycle is dropped
        drive(1, 0, 0, 5'd0, 8'h00, 1, 0, 5'd3, 8'h00, 0);
        chk("rstrd_gnt", host_gnt_o, 1);
        nxt();
        drive(0, 0, 0, 5'd0, 8'h00, 0, 0, 5'd0, 8'h00, 0);
        chk("rstrd_rvalid", host_rvalid_o, 0);
        nxt();
        nxt();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
